buffer_dati: RTL and testbench

//  Word buffer on the memory side of the mining write/read sequencer.

---
 rtl/buffer_dati.sv | 137 +++++++++++++
 tb/tb_buffer_dati.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_dati.sv
// buffer_dati: DEPTH-word write/read buffer on the memory side of the mining sequencer.
// Define PARITY_EN to store an even-parity bit per word and flag read mismatches on parity_err.
module buffer_dati #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   input  logic [8:0]        indirizzo_read,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_valid,
   output logic              fine_scrittura,
   output logic              fine_lettura,
   output logic              parity_err
);

   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0]  LAST    = 9'(DEPTH - 1);
   localparam logic [9:0]  DEPTH_L = 10'(DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      FULL   = 3'd2,
      R_ADDR = 3'd3,
      R_DATA = 3'd4,
      R_WAIT = 3'd5,
      DONE   = 3'd6
   } state_t;

   state_t            state;
   logic [8:0]        wr_ptr;
   logic              rd_last;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_en;
   logic              addr_oor;
   logic [AW-1:0]     rd_idx;

   assign wr_en    = (state == WRITE) && we && data_valid;
   assign addr_oor = {1'b0, indirizzo_read} >= DEPTH_L;
   assign rd_idx   = indirizzo_read[AW-1:0];

   // Storage has no reset: contents survive a reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= data_in;
   end

   // The R_ADDR read lands directly in data_out, so the word and its pulses show during R_DATA.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_last        <= 1'b0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         fine_scrittura <= 1'b0;
         fine_lettura   <= 1'b0;
      end else begin
         data_out_valid <= 1'b0;
         fine_scrittura <= 1'b0;
         fine_lettura   <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (we) begin
                  state  <= WRITE;
                  wr_ptr <= '0;
               end else if (re) begin
                  state <= R_ADDR;
               end
            end
            WRITE: begin
               if (wr_en) begin
                  if (wr_ptr == LAST) begin
                     fine_scrittura <= 1'b1;
                     state          <= FULL;
                  end else begin
                     wr_ptr <= wr_ptr + 9'd1;
                  end
               end
            end
            FULL: begin
               if (re && !we) state <= R_ADDR;
            end
            R_ADDR: begin
               if (!re) begin
                  state <= IDLE;
               end else if (addr_oor) begin
                  data_out       <= '0;
                  data_out_valid <= 1'b1;
                  fine_lettura   <= 1'b1;
                  state          <= DONE;
               end else begin
                  data_out       <= mem[rd_idx];
                  data_out_valid <= 1'b1;
                  rd_last        <= (indirizzo_read == LAST);
                  fine_lettura   <= (indirizzo_read == LAST);
                  fine_scrittura <= (indirizzo_read != LAST);
                  state          <= R_DATA;
               end
            end
            R_DATA: begin
               if (!re)          state <= IDLE;
               else if (rd_last) state <= DONE;
               else              state <= R_WAIT;
            end
            R_WAIT: begin
               state <= re ? R_ADDR : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PARITY_EN
   logic par_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) par_mem[wr_ptr[AW-1:0]] <= ^data_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= (state == R_ADDR) && re && !addr_oor &&
                       ((^mem[rd_idx]) != par_mem[rd_idx]);
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_buffer_dati.sv
// Scoreboard bench for buffer_dati: stimulus pushes expected output events, a negedge monitor pops and compares.
module tb_buffer_dati;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned NO_ABORT = 99;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          we = 1'b0;
   logic          re = 1'b0;
   logic          data_valid = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [8:0]    indirizzo_read = '0;
   logic [DW-1:0] data_out;
   logic          data_out_valid;
   logic          fine_scrittura;
   logic          fine_lettura;
   logic          parity_err;

   buffer_dati #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .we             (we),
      .re             (re),
      .data_in        (data_in),
      .data_valid     (data_valid),
      .indirizzo_read (indirizzo_read),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .fine_scrittura (fine_scrittura),
      .fine_lettura   (fine_lettura),
      .parity_err     (parity_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      bit            chk_data;
      bit            dv;
      bit            fs;
      bit            fl;
      bit            pe;
      int unsigned   cyc;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   int unsigned   cyc = 0;
   int unsigned   errors = 0;
   int unsigned   checks = 0;
   logic [DW-1:0] model [DEPTH];
   int            corrupt_addr = -1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset && (data_out_valid || fine_scrittura || fine_lettura || parity_err)) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output cyc=%0d got dv=%0b fs=%0b fl=%0b pe=%0b data=%h, required no activity",
                     cyc, data_out_valid, fine_scrittura, fine_lettura, parity_err, data_out);
         end else begin
            mon_e = sb.pop_front();
            if (data_out_valid !== mon_e.dv || fine_scrittura !== mon_e.fs ||
                fine_lettura !== mon_e.fl || parity_err !== mon_e.pe || cyc != mon_e.cyc ||
                (mon_e.chk_data && data_out !== mon_e.data)) begin
               errors++;
               $display("FAIL event got cyc=%0d dv=%0b fs=%0b fl=%0b pe=%0b data=%h, required cyc=%0d dv=%0b fs=%0b fl=%0b pe=%0b data=%h",
                        cyc, data_out_valid, fine_scrittura, fine_lettura, parity_err, data_out,
                        mon_e.cyc, mon_e.dv, mon_e.fs, mon_e.fl, mon_e.pe, mon_e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input bit chk, input bit dv, input bit fs,
                           input bit fl, input bit pe, input int unsigned c);
      exp_t e;
      e.data = d; e.chk_data = chk; e.dv = dv; e.fs = fs; e.fl = fl; e.pe = pe; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (data_out !== '0 || data_out_valid !== 1'b0 || fine_scrittura !== 1'b0 ||
          fine_lettura !== 1'b0 || parity_err !== 1'b0) begin
         errors++;
         $display("FAIL %s got data=%h dv=%0b fs=%0b fl=%0b pe=%0b, required all 0",
                  name, data_out, data_out_valid, fine_scrittura, fine_lettura, parity_err);
      end
   endtask

   function automatic bit pe_exp(input int unsigned a);
`ifdef PARITY_EN
      return (int'(a) == corrupt_addr);
`else
      return 1'b0;
`endif
   endfunction

   // Writes DEPTH words base+n; optional data_valid gaps and a 3-cycle we drop after word 7.
   task automatic write_block(input logic [DW-1:0] base, input bit gaps, input bit with_re);
      int unsigned n = 0;
      int unsigned guard = 0;
      int unsigned idle_cnt = 0;
      int          last_gap = -1;
      we = 1'b1; re = with_re; data_valid = 1'b0; tick();
      while (n < DEPTH && guard < 200) begin
         guard++;
         if (gaps && n == 8 && idle_cnt < 3) begin
            we = 1'b0; data_valid = 1'b1; data_in = 32'hBAD0_0000 + idle_cnt;
            idle_cnt++;
         end else if (gaps && (n % 3) == 1 && last_gap != int'(n)) begin
            we = 1'b1; data_valid = 1'b0; data_in = 32'hBAD1_0000;
            last_gap = int'(n);
         end else begin
            we = 1'b1; data_valid = 1'b1; data_in = base + n;
            model[n] = base + n;
            if (n == DEPTH - 1) push_exp('0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, cyc + 1);
            n++;
         end
         tick();
      end
      if (n < DEPTH) begin
         checks++; errors++;
         $display("FAIL write_guard got %0d words, required %0d", n, DEPTH);
      end
      we = 1'b1; data_valid = 1'b1; data_in = 32'hDEAD_BEEF; tick();
      we = 1'b0; re = 1'b0; data_valid = 1'b0; tick();
   endtask

   // Model sequencer: address +1 per fine_scrittura, drops re on fine_lettura.
   task automatic read_block(input int unsigned start, input int unsigned abort_at);
      int unsigned k0;
      int unsigned a;
      int unsigned guard = 0;
      int unsigned seen = 0;
      bit done = 1'b0;
      bit aborted = 1'b0;
      indirizzo_read = 9'(start); we = 1'b0; re = 1'b1; k0 = cyc;
      for (int unsigned i = 0; i < abort_at; i++) begin
         a = start + i;
         if (a >= DEPTH) begin
            push_exp('0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, k0 + 2 + 3 * i);
            break;
         end
         push_exp(model[a], 1'b1, 1'b1, a != DEPTH - 1, a == DEPTH - 1, pe_exp(a), k0 + 2 + 3 * i);
         if (a == DEPTH - 1) break;
      end
      while (!done && guard < 200) begin
         tick();
         guard++;
         if (data_out_valid && seen == abort_at) begin
            reset = 1'b0;
            #1 check_reset_outputs("reset_mid_read");
            aborted = 1'b1;
            done = 1'b1;
         end else begin
            if (data_out_valid) seen++;
            if (fine_scrittura) indirizzo_read = indirizzo_read + 9'd1;
            if (fine_lettura) begin
               re = 1'b0;
               done = 1'b1;
            end
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL read_timeout got %0d words, required completion", seen);
      end
      re = 1'b0;
      tick();
      if (aborted) begin
         reset = 1'b1;
         tick();
      end
   endtask

   initial begin
      repeat (2) tick();
      check_reset_outputs("reset_state");
      reset = 1'b1;
      tick();

      // Reset during a write at wr_ptr=5
      we = 1'b1; data_valid = 1'b0; tick();
      for (int i = 0; i < 5; i++) begin
         data_valid = 1'b1; data_in = 32'h0A0 + i; tick();
      end
      #2 reset = 1'b0;
      #1 check_reset_outputs("reset_mid_write");
      we = 1'b0; data_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      write_block(32'h100, 1'b0, 1'b0);
      read_block(0, NO_ABORT);
      read_block(0, 4);
      read_block(0, NO_ABORT);
      read_block(DEPTH - 1, NO_ABORT);
      read_block(DEPTH, NO_ABORT);

      write_block(32'h200, 1'b1, 1'b0);
      read_block(0, NO_ABORT);

      write_block(32'h300, 1'b0, 1'b1);
      read_block(0, NO_ABORT);

      dut.mem[3] = dut.mem[3] ^ 32'h0000_0001;
      model[3] = model[3] ^ 32'h0000_0001;
      corrupt_addr = 3;
      read_block(0, NO_ABORT);

      repeat (4) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending events, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
